// File: rtl/seg7_scan_drv.sv
// Eight-digit common-anode seven-segment scan driver with frame-synchronous shadow latching.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_drv #(
    parameter int unsigned SCAN_CNT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disp_data,
    input  logic [7:0]  point,
    input  logic [7:0]  blank,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int unsigned PW = $clog2(SCAN_CNT);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_CNT - 1);

    logic [PW-1:0] r_pre;
    logic [2:0]    r_dig;
    logic [31:0]   r_sh_data;
    logic [7:0]    r_sh_point;
    logic [7:0]    r_sh_blank;
    logic          r_prime;

    logic [31:0]   w_sh_shift;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;
    logic [7:0]    w_lz;
    logic          w_blk;
    logic [7:0]    w_an;
    logic [7:0]    w_seg;
    logic          w_pre_wrap;

    // Leading-zero mask is derived from the shadow word so it only changes at frame boundaries
`ifdef SEG7_LZB_EN
    logic w_acc;
    always_comb begin
        w_lz  = '0;
        w_acc = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            w_acc   = w_acc & (r_sh_data[4*k +: 4] == 4'h0);
            w_lz[k] = w_acc;
        end
    end
`else
    always_comb begin
        w_lz = '0;
    end
`endif

    always_comb begin
        w_sh_shift = r_sh_data >> {r_dig, 2'b00};
        w_nib      = w_sh_shift[3:0];
        w_pre_wrap = (r_pre == PRE_LAST);
        w_blk      = r_sh_blank[r_dig] | w_lz[r_dig];
        case (w_nib)
            4'h0:    w_hex = 7'h40;
            4'h1:    w_hex = 7'h79;
            4'h2:    w_hex = 7'h24;
            4'h3:    w_hex = 7'h30;
            4'h4:    w_hex = 7'h19;
            4'h5:    w_hex = 7'h12;
            4'h6:    w_hex = 7'h02;
            4'h7:    w_hex = 7'h78;
            4'h8:    w_hex = 7'h00;
            4'h9:    w_hex = 7'h10;
            4'hA:    w_hex = 7'h08;
            4'hB:    w_hex = 7'h03;
            4'hC:    w_hex = 7'h46;
            4'hD:    w_hex = 7'h21;
            4'hE:    w_hex = 7'h06;
            default: w_hex = 7'h0E;
        endcase
        w_an  = w_blk ? 8'hFF : ~(8'h01 << r_dig);
        w_seg = w_blk ? 8'hFF : {~r_sh_point[r_dig], w_hex};
    end

    // Prime load after reset, then prescaled digit scan with shadow reload at the 7->0 wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre      <= '0;
            r_dig      <= '0;
            r_sh_data  <= '0;
            r_sh_point <= '0;
            r_sh_blank <= 8'hFF;
            r_prime    <= 1'b1;
            an         <= 8'hFF;
            seg        <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= w_an;
            seg        <= w_seg;
            frame_tick <= 1'b0;
            if (r_prime) begin
                r_prime    <= 1'b0;
                r_sh_data  <= disp_data;
                r_sh_point <= point;
                r_sh_blank <= blank;
                frame_tick <= 1'b1;
            end else if (w_pre_wrap) begin
                r_pre <= '0;
                r_dig <= r_dig + 3'd1;
                if (r_dig == 3'd7) begin
                    r_sh_data  <= disp_data;
                    r_sh_point <= point;
                    r_sh_blank <= blank;
                    frame_tick <= 1'b1;
                end
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Randomized bench for seg7_scan_drv against a frame/time-indexed reference model.
// Honours SEG7_LZB_EN the same way as the design build.
module tb_seg7_scan_drv;

    localparam int unsigned SC    = 4;
    localparam int unsigned FRAME = 8 * SC;
`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] disp_data = '0;
    logic [7:0]  point = '0;
    logic [7:0]  blank = '0;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned n_edge = 0;

    // Model shadow: what was captured at the most recent load edge
    logic [31:0] m_data  = '0;
    logic [7:0]  m_point = '0;
    logic [7:0]  m_blank = 8'hFF;

    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg7_scan_drv #(.SCAN_CNT(SC)) dut (
        .clk        (clk),
        .rst        (rst),
        .disp_data  (disp_data),
        .point      (point),
        .blank      (blank),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, n_edge);
        end
    endtask

    // Edge n after release: n=1 is the prime load; output after edge n shows digit ((n-2)/SC)%8
    task automatic step();
        int          d;
        bit          blk;
        logic [7:0]  e_an;
        logic [7:0]  e_seg;
        logic        e_tick;
        logic [7:0]  glyph;
        @(posedge clk);
        n_edge++;
        e_tick = ((n_edge % FRAME) == 1);
        if (n_edge < 2) begin
            e_an  = 8'hFF;
            e_seg = 8'hFF;
        end else begin
            d   = int'(((n_edge - 2) / SC) % 8);
            blk = m_blank[d];
            if (LZB && d >= 1 && (m_data >> (4 * d)) == 32'd0) blk = 1'b1;
            if (blk) begin
                e_an  = 8'hFF;
                e_seg = 8'hFF;
            end else begin
                glyph = hex_tbl[m_data[4*d +: 4]];
                e_an  = ~(8'h01 << d);
                e_seg = {~m_point[d], glyph[6:0]};
            end
        end
        if (e_tick) begin
            m_data  = disp_data;
            m_point = point;
            m_blank = blank;
        end
        @(negedge clk);
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic model_reset();
        n_edge  = 0;
        m_data  = '0;
        m_point = '0;
        m_blank = 8'hFF;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_tick", 32'(frame_tick), 32'h0);

        disp_data = 32'h0123ABCD;
        point     = 8'h00;
        blank     = 8'h00;
        rst       = 1'b0;
        model_reset();
        repeat (2 * FRAME + 2) step();

        // Mid-frame change must not appear until the next boundary
        for (int i = 0; i < 40 && (((n_edge - 1) / SC) % 8) != 3; i++) step();
        disp_data = 32'hFFFFFFFF;
        repeat (FRAME + 8) step();

        point = 8'h01;
        blank = 8'h80;
        disp_data = 32'h0123ABCD;
        repeat (2 * FRAME) step();

        point = 8'h00;
        blank = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                disp_data = 32'($urandom) >> (4 * $urandom_range(0, 8));
                point     = 8'($urandom);
                blank     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            end
            step();
        end

        // Asynchronous reset while digit 5 is lit
        disp_data = 32'h76543210;
        point = 8'h00;
        blank = 8'h00;
        for (int i = 0; i < 80 && (n_edge < 2 || (((n_edge - 2) / SC) % 8) != 5); i++) step();
        #1 rst = 1'b1;
        #1;
        chk("async_an", 32'(an), 32'hFF);
        chk("async_seg", 32'(seg), 32'hFF);
        chk("async_tick", 32'(frame_tick), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("held_an", 32'(an), 32'hFF);
        chk("held_seg", 32'(seg), 32'hFF);
        rst = 1'b0;
        model_reset();
        repeat (FRAME + 4) step();

        disp_data = 32'h0000002A;
        repeat (2 * FRAME) step();
        disp_data = 32'h00000000;
        repeat (2 * FRAME) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
